// File: rtl/rca_wb_sequencer_pkg.sv
// rca_wb_sequencer_pkg: shared types for the RCA writeback sequencer.
package rca_wb_sequencer_pkg;
    localparam int WB_NUM_RCAS = 4;
    localparam int WB_RCA_W = WB_NUM_RCAS > 1 ? $clog2(WB_NUM_RCAS) : 1;
    localparam int WB_PORTS = 2;
    localparam int WB_ID_W = 3;

    typedef enum logic {RUN, FLUSH} wb_seq_state_t;

    typedef struct packed {
        logic [WB_ID_W-1:0]  id;
        logic                fb;
        logic [WB_RCA_W-1:0] rca_sel;
        logic [WB_PORTS-1:0] port_mask;
    } rca_wb_entry_t;
endpackage

// File: rtl/rca_wb_sequencer_if.sv
// rca_wb_sequencer_if: issue handshake and writeback bundle of the RCA sequencer.
interface rca_wb_sequencer_if #(
    parameter int NUM_WRITE_PORTS = 2,
    parameter int XLEN = 32,
    parameter int ID_W = 3,
    parameter int RCA_W = 2
);
    logic                            issue_valid;
    logic                            issue_ready;
    logic                            issue_is_use;
    logic [ID_W-1:0]                 issue_id;
    logic                            issue_fb;
    logic [RCA_W-1:0]                issue_rca_sel;
    logic [NUM_WRITE_PORTS-1:0]      issue_port_mask;
    logic                            wb_done;
    logic                            wb_is_use;
    logic [ID_W-1:0]                 wb_id;
    logic [NUM_WRITE_PORTS*XLEN-1:0] wb_rd;
    logic [NUM_WRITE_PORTS-1:0]      wb_port_mask;

    modport master (
        output issue_valid, issue_is_use, issue_id, issue_fb, issue_rca_sel, issue_port_mask,
        input  issue_ready, wb_done, wb_is_use, wb_id, wb_rd, wb_port_mask
    );
    modport slave (
        input  issue_valid, issue_is_use, issue_id, issue_fb, issue_rca_sel, issue_port_mask,
        output issue_ready, wb_done, wb_is_use, wb_id, wb_rd, wb_port_mask
    );
endinterface

// File: rtl/rca_wb_sequencer_fifo.sv
// rca_id_fifo: small in-order FIFO with fill count and synchronous clear.
module rca_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    // explicit wrap so non-power-of-two depths work
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/rca_wb_sequencer.sv
// rca_wb_sequencer: in-order RCA use-instruction writeback with config-ack arbitration and timed IO flush.
module rca_wb_sequencer import rca_wb_sequencer_pkg::*; #(
    parameter int NUM_RCAS = WB_NUM_RCAS,
    parameter int NUM_WRITE_PORTS = WB_PORTS,
    parameter int XLEN = 32,
    parameter int ID_W = WB_ID_W,
    parameter int DEPTH = 4,
    parameter int CFG_ACK_DEPTH = 3,
    parameter int FLUSH_CYCLES = 2,
    localparam int RCA_W = NUM_RCAS > 1 ? $clog2(NUM_RCAS) : 1,
    localparam int OCC_W = $clog2(DEPTH+1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    rca_wb_sequencer_if.slave               bus,
    input  logic [NUM_WRITE_PORTS-1:0]      port_valid,
    input  logic [NUM_WRITE_PORTS*XLEN-1:0] port_data,
    input  logic                            flush,
    output logic [NUM_WRITE_PORTS-1:0]      io_fifo_pop,
    output logic                            head_fb,
    output logic [RCA_W-1:0]                head_rca_sel,
    output logic                            io_units_rst,
    output logic                            config_locked,
    output logic [OCC_W-1:0]                occupancy
);
    localparam int CCW = $clog2(CFG_ACK_DEPTH+1);
    localparam int FCW = $clog2(FLUSH_CYCLES+1);

    wb_seq_state_t state, state_nxt;
    logic [FCW-1:0] fcnt, fcnt_nxt;
    rca_wb_entry_t push_e, head_e;
    logic [ID_W-1:0] cfg_head;
    logic [CCW-1:0] cfg_cnt;
    logic [NUM_WRITE_PORTS*XLEN-1:0] rd_masked;
    logic run, accept, use_push, cfg_push, commit, ack;

    assign run = state == RUN;
    assign config_locked = occupancy != '0 || state == FLUSH;
    assign io_units_rst = state == FLUSH;
    assign bus.issue_ready = run && !flush && (bus.issue_is_use ? occupancy < OCC_W'(DEPTH)
                                                : !config_locked && cfg_cnt < CCW'(CFG_ACK_DEPTH));
    assign accept = bus.issue_valid && bus.issue_ready;
    assign use_push = accept && bus.issue_is_use;
    assign cfg_push = accept && !bus.issue_is_use;
    assign push_e = '{id: bus.issue_id, fb: bus.issue_fb, rca_sel: bus.issue_rca_sel,
                      port_mask: bus.issue_port_mask};
    // an empty mask satisfies the valid check, so such entries retire as soon as they reach the head
    assign commit = run && !flush && occupancy != '0 &&
                    (port_valid & head_e.port_mask) == head_e.port_mask;
    assign ack = cfg_cnt != '0 && !commit;
    assign io_fifo_pop = commit ? head_e.port_mask : '0;
    assign head_fb = occupancy != '0 && head_e.fb;
    assign head_rca_sel = occupancy != '0 ? head_e.rca_sel : '0;

    for (genvar g = 0; g < NUM_WRITE_PORTS; g++) begin : g_mask
        assign rd_masked[g*XLEN +: XLEN] = head_e.port_mask[g] ? port_data[g*XLEN +: XLEN] : '0;
    end

    rca_id_fifo #(.DEPTH(DEPTH), .W($bits(rca_wb_entry_t))) u_use_q (
        .clk(clk), .rst_n(rst_n), .clr(flush), .push(use_push), .pop(commit),
        .din(push_e), .dout(head_e), .count(occupancy)
    );

    rca_id_fifo #(.DEPTH(CFG_ACK_DEPTH), .W(ID_W)) u_cfg_q (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .push(cfg_push), .pop(ack),
        .din(bus.issue_id), .dout(cfg_head), .count(cfg_cnt)
    );

    always_comb begin
        state_nxt = state;
        fcnt_nxt = fcnt;
        if (run) begin
            if (flush) begin
                state_nxt = FLUSH;
                fcnt_nxt = FCW'(FLUSH_CYCLES-1);
            end
        end else if (fcnt == '0) state_nxt = RUN;
        else fcnt_nxt = fcnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            fcnt <= '0;
            bus.wb_done <= 1'b0;
            bus.wb_is_use <= 1'b0;
            bus.wb_id <= '0;
            bus.wb_rd <= '0;
            bus.wb_port_mask <= '0;
        end else begin
            state <= state_nxt;
            fcnt <= fcnt_nxt;
            bus.wb_done <= commit || ack;
            bus.wb_is_use <= commit;
            bus.wb_id <= commit ? head_e.id : ack ? cfg_head : '0;
            bus.wb_rd <= commit ? rd_masked : '0;
            bus.wb_port_mask <= commit ? head_e.port_mask : '0;
        end
    end
endmodule

// File: tb/tb_rca_wb_sequencer.sv
// tb_rca_wb_sequencer: directed checks of commit timing, config acks, flush and reset.
module tb_rca_wb_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] port_valid = '0;
    logic [63:0] port_data = '0;
    logic flush = 1'b0;
    logic [1:0] io_fifo_pop;
    logic head_fb;
    logic [1:0] head_rca_sel;
    logic io_units_rst;
    logic config_locked;
    logic [2:0] occupancy;
    int n_cmp = 0;
    int n_err = 0;

    rca_wb_sequencer_if #(.NUM_WRITE_PORTS(2), .XLEN(32), .ID_W(3), .RCA_W(2)) bus ();

    rca_wb_sequencer dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .port_valid(port_valid), .port_data(port_data),
        .flush(flush), .io_fifo_pop(io_fifo_pop), .head_fb(head_fb), .head_rca_sel(head_rca_sel),
        .io_units_rst(io_units_rst), .config_locked(config_locked), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_issue(input logic v, input logic u, input logic [2:0] id, input logic fb,
                             input logic [1:0] rca, input logic [1:0] m);
        bus.issue_valid = v;
        bus.issue_is_use = u;
        bus.issue_id = id;
        bus.issue_fb = fb;
        bus.issue_rca_sel = rca;
        bus.issue_port_mask = m;
    endtask

    initial begin
        set_issue(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", bus.issue_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_wb_done", bus.wb_done, 0);
        chk("rst_io_rst", io_units_rst, 0);

        // use id 5, both ports; port 1 arrives late
        set_issue(1, 1, 5, 1, 2, 2'b11);
        #1 chk("a_ready", bus.issue_ready, 1);
        tick();
        bus.issue_valid = 0;
        chk("a_occ", occupancy, 1);
        chk("a_head_fb", head_fb, 1);
        chk("a_head_rca", head_rca_sel, 2);
        chk("a_locked", config_locked, 1);
        port_data = {32'hB, 32'hA};
        for (int i = 0; i < 3; i++) begin
            port_valid = 2'b01;
            #1 chk("a_pop_wait", io_fifo_pop, 0);
            tick();
            chk("a_wb_wait", bus.wb_done, 0);
        end
        port_valid = 2'b11;
        #1 chk("a_pop", io_fifo_pop, 2'b11);
        tick();
        port_valid = 2'b00;
        #1;
        chk("a_wb_done", bus.wb_done, 1);
        chk("a_wb_use", bus.wb_is_use, 1);
        chk("a_wb_id", bus.wb_id, 5);
        chk("a_wb_rd", bus.wb_rd, 64'h0000000B_0000000A);
        chk("a_wb_mask", bus.wb_port_mask, 2'b11);
        chk("a_pop_once", io_fifo_pop, 0);
        chk("a_occ0", occupancy, 0);
        tick();
        chk("a_wb_clear", bus.wb_done, 0);

        // fill to DEPTH, then ready gating
        for (int i = 0; i < 4; i++) begin
            set_issue(1, 1, 3'(i), 0, 0, 2'b01);
            tick();
        end
        chk("b_occ_full", occupancy, 4);
        set_issue(1, 1, 4, 0, 0, 2'b01);
        #1 chk("b_full_ready", bus.issue_ready, 0);
        bus.issue_is_use = 0;
        #1 chk("b_cfg_locked", bus.issue_ready, 0);
        bus.issue_is_use = 1;
        port_valid = 2'b01;
        #1 chk("b_full_pop_ready", bus.issue_ready, 0);
        tick();
        chk("b_occ3", occupancy, 3);
        chk("b_wb_id0", bus.wb_id, 0);
        chk("b_wb_rd0", bus.wb_rd, 64'h0000000A);
        #1 chk("b_ready3", bus.issue_ready, 1);
        tick();
        bus.issue_valid = 0;
        chk("b_occ_same", occupancy, 3);
        chk("b_wb_id1", bus.wb_id, 1);
        for (int i = 2; i < 5; i++) begin
            tick();
            chk("b_drain_id", bus.wb_id, 64'(i));
            chk("b_drain_done", bus.wb_done, 1);
        end
        chk("b_drain_occ", occupancy, 0);
        port_valid = 0;
        tick();
        chk("b_idle", bus.wb_done, 0);

        // use commit followed by a config ack
        set_issue(1, 1, 6, 0, 0, 2'b01);
        tick();
        set_issue(1, 0, 2, 0, 0, 0);
        port_valid = 2'b01;
        #1 chk("c_cfg_locked", bus.issue_ready, 0);
        bus.issue_valid = 0;
        tick();
        port_valid = 0;
        chk("c_use_wb", bus.wb_is_use, 1);
        chk("c_use_id", bus.wb_id, 6);
        bus.issue_valid = 1;
        #1 chk("c_cfg_ready", bus.issue_ready, 1);
        tick();
        bus.issue_valid = 0;
        chk("c_ack_not_yet", bus.wb_done, 0);
        tick();
        chk("c_ack_done", bus.wb_done, 1);
        chk("c_ack_use", bus.wb_is_use, 0);
        chk("c_ack_id", bus.wb_id, 2);
        chk("c_ack_rd", bus.wb_rd, 0);
        tick();
        chk("c_ack_once", bus.wb_done, 0);

        // flush with two entries and all ports valid
        set_issue(1, 1, 1, 1, 0, 2'b11);
        tick();
        set_issue(1, 1, 2, 0, 1, 2'b11);
        tick();
        bus.issue_valid = 0;
        chk("d_occ2", occupancy, 2);
        flush = 1;
        port_valid = 2'b11;
        #1;
        chk("d_no_pop", io_fifo_pop, 0);
        chk("d_ready", bus.issue_ready, 0);
        tick();
        flush = 0;
        port_valid = 0;
        #1;
        chk("d_io_rst1", io_units_rst, 1);
        chk("d_occ0", occupancy, 0);
        chk("d_no_wb", bus.wb_done, 0);
        chk("d_locked", config_locked, 1);
        chk("d_ready_fl", bus.issue_ready, 0);
        tick();
        chk("d_io_rst2", io_units_rst, 1);
        tick();
        chk("d_io_rst_off", io_units_rst, 0);
        chk("d_unlocked", config_locked, 0);

        // config ack keeps draining across a flush
        set_issue(1, 0, 4, 0, 0, 0);
        #1 chk("e_ready", bus.issue_ready, 1);
        tick();
        bus.issue_valid = 0;
        flush = 1;
        tick();
        flush = 0;
        chk("e_ack_done", bus.wb_done, 1);
        chk("e_ack_use", bus.wb_is_use, 0);
        chk("e_ack_id", bus.wb_id, 4);
        chk("e_in_flush", io_units_rst, 1);
        repeat (2) tick();

        // empty-mask use retires at the head
        set_issue(1, 1, 7, 0, 3, 2'b00);
        tick();
        bus.issue_valid = 0;
        chk("f_pre_wb", bus.wb_done, 0);
        tick();
        chk("f_wb_done", bus.wb_done, 1);
        chk("f_wb_use", bus.wb_is_use, 1);
        chk("f_wb_id", bus.wb_id, 7);
        chk("f_wb_rd", bus.wb_rd, 0);
        chk("f_wb_mask", bus.wb_port_mask, 0);
        chk("f_occ", occupancy, 0);

        // asynchronous reset with entries in flight
        for (int i = 0; i < 3; i++) begin
            set_issue(1, 1, 3'(i + 1), 1, 1, 2'b11);
            tick();
        end
        bus.issue_valid = 0;
        chk("g_occ3", occupancy, 3);
        #2 rst_n = 0;
        #1;
        chk("g_occ_rst", occupancy, 0);
        chk("g_fb_rst", head_fb, 0);
        chk("g_rca_rst", head_rca_sel, 0);
        chk("g_lock_rst", config_locked, 0);
        chk("g_wb_rst", bus.wb_done, 0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("g_ready_rel", bus.issue_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
